// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one fixed-latency logic evaluation unit among NREQ requesters.
// Tags ride a LAT-deep pipeline alongside the unit so each result is routed back to its issuer.
module logic_unit_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [3:0]          unit_in,
  output logic                unit_launch,
  input  logic [5:0]          unit_out,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [5:0]          rsp_data,
  output logic                busy,
  output logic [CNTW-1:0]     issue_count
);

  localparam int unsigned IdW = $clog2(NREQ);
  typedef logic [IdW-1:0] id_t;

  id_t                ptr_q, ptr_d;
  logic [LAT-1:0]     stg_vld_q, stg_vld_d;
  id_t  [LAT-1:0]     stg_id_q, stg_id_d;
  logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [5:0]         rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic               grant_vld;
  id_t                grant_id;
  logic [NREQ-1:0]    grant_oh;
  logic               xfer;
  int unsigned        idx;

  // Scan requesters starting at the pointer; first valid one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = id_t'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_oh[i] = grant_vld && (grant_id == id_t'(i)) && en && !rst;
    end
  end

  assign req_ready   = grant_oh;
  assign xfer        = |grant_oh;
  assign unit_launch = xfer;

  always_comb begin
    unit_in = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) unit_in = req_data[4*i +: 4];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = id_t'((int'(grant_id) + 1) % NREQ);
  end

  always_comb begin
    stg_vld_d    = stg_vld_q;
    stg_id_d     = stg_id_q;
    stg_vld_d[0] = xfer;
    stg_id_d[0]  = grant_id;
    for (int unsigned s = 1; s < LAT; s++) begin
      stg_vld_d[s] = stg_vld_q[s-1];
      stg_id_d[s]  = stg_id_q[s-1];
    end
  end

  // The last tag stage lines up with unit_out being valid.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (stg_vld_q[LAT-1]) begin
      rsp_data_d = unit_out;
      for (int unsigned i = 0; i < NREQ; i++) begin
        rsp_valid_d[i] = (stg_id_q[LAT-1] == id_t'(i));
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      stg_vld_q   <= '0;
      stg_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      stg_vld_q   <= stg_vld_d;
      stg_id_q    <= stg_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = (|stg_vld_q) | (|rsp_valid_q);
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler with a 2-cycle registered model of the shared unit.
// A second instance with a 3-bit counter shares the stimulus to exercise saturation.
module tb_logic_unit_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  unit_in;
  logic        unit_launch;
  logic [5:0]  unit_out;
  logic [3:0]  rsp_valid;
  logic [5:0]  rsp_data;
  logic        busy;
  logic [15:0] issue_count;

  logic [3:0]  s_req_ready;
  logic [3:0]  s_unit_in;
  logic        s_unit_launch;
  logic [3:0]  s_rsp_valid;
  logic [5:0]  s_rsp_data;
  logic        s_busy;
  logic [2:0]  s_issue_count;

  logic [5:0]  m1, m2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  logic_unit_scheduler #(.NREQ(4), .LAT(2), .CNTW(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .unit_in    (unit_in),
    .unit_launch(unit_launch),
    .unit_out   (unit_out),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .issue_count(issue_count)
  );

  logic_unit_scheduler #(.NREQ(4), .LAT(2), .CNTW(3)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (s_req_ready),
    .unit_in    (s_unit_in),
    .unit_launch(s_unit_launch),
    .unit_out   (unit_out),
    .rsp_valid  (s_rsp_valid),
    .rsp_data   (s_rsp_data),
    .busy       (s_busy),
    .issue_count(s_issue_count)
  );

  function automatic logic [5:0] unit_f(input logic [3:0] x);
    return ~{x[3], x[2], x[1], x[0], x[3], x[2]};
  endfunction

  always_ff @(posedge clk) begin
    m1 <= unit_f(unit_in);
    m2 <= m1;
  end
  assign unit_out = m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = '0;
    req_data  = '0;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_launch", 32'(unit_launch), 0);
    chk("rst_unit_in", 32'(unit_in), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(issue_count), 0);

    // Single request latency
    nxt();
    req_valid = 4'b0001;
    req_data  = 16'h000A;
    #2;
    chk("single_ready", 32'(req_ready), 32'b0001);
    chk("single_launch", 32'(unit_launch), 1);
    chk("single_unit_in", 32'(unit_in), 32'b1010);
    nxt();
    req_valid = '0;
    #2;
    chk("single_c1_rsp", 32'(rsp_valid), 0);
    chk("single_c1_busy", 32'(busy), 1);
    nxt(); #2;
    chk("single_c2_rsp", 32'(rsp_valid), 0);
    nxt(); #2;
    chk("single_c3_rsp", 32'(rsp_valid), 32'b0001);
    chk("single_c3_data", 32'(rsp_data), 32'b010101);
    chk("single_count", 32'(issue_count), 1);
    nxt(); #2;
    chk("single_c4_rsp", 32'(rsp_valid), 0);
    chk("single_c4_busy", 32'(busy), 0);

    // Round-robin fairness from pointer 0
    nxt();
    rst = 1'b1;
    nxt();
    rst      = 1'b0;
    req_data = 16'hC53E;
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #2;
      if (k < 8) begin
        chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
        chk("rr_unit_in", 32'(unit_in), 32'(req_data[4*(k%4) +: 4]));
      end
      if (k >= 3) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((k - 3) % 4)));
        chk("rr_rsp_data", 32'(rsp_data), 32'(unit_f(req_data[4*((k-3)%4) +: 4])));
      end else begin
        chk("rr_rsp_idle", 32'(rsp_valid), 0);
      end
      nxt();
    end
    #2;
    chk("rr_count", 32'(issue_count), 8);
    chk("rr_busy", 32'(busy), 0);
    chk("sat_after8", 32'(s_issue_count), 7);

    // Pointer wrap past idle requesters: grant 1 moves pointer to 2
    req_valid = 4'b0010;
    #2;
    chk("wrap_pre", 32'(req_ready), 32'b0010);
    nxt();
    req_valid = 4'b0011;
    #2;
    chk("wrap_g0", 32'(req_ready), 32'b0001);
    nxt(); #2;
    chk("wrap_g1", 32'(req_ready), 32'b0010);
    nxt(); #2;
    chk("wrap_g0b", 32'(req_ready), 32'b0001);
    nxt();
    req_valid = '0;
    repeat (4) nxt();

    // Move pointer back to 0 via requester 3
    req_valid = 4'b1000;
    #2;
    chk("ptr3_ready", 32'(req_ready), 32'b1000);
    nxt();
    req_valid = '0;
    repeat (4) nxt();

    // en gating
    req_valid = 4'hF;
    req_data  = 16'hC53E;
    #2;
    chk("en_g0", 32'(req_ready), 32'b0001);
    nxt(); #2;
    chk("en_g1", 32'(req_ready), 32'b0010);
    nxt();
    en = 1'b0;
    #2;
    chk("en_off_c2_ready", 32'(req_ready), 0);
    chk("en_off_c2_launch", 32'(unit_launch), 0);
    chk("en_off_c2_rsp", 32'(rsp_valid), 0);
    nxt(); #2;
    chk("en_off_c3_ready", 32'(req_ready), 0);
    chk("en_off_c3_rsp", 32'(rsp_valid), 32'b0001);
    chk("en_off_c3_data", 32'(rsp_data), 32'b000100);
    nxt(); #2;
    chk("en_off_c4_ready", 32'(req_ready), 0);
    chk("en_off_c4_rsp", 32'(rsp_valid), 32'b0010);
    chk("en_off_c4_data", 32'(rsp_data), 32'b110011);
    nxt();
    en = 1'b1;
    #2;
    chk("en_resume", 32'(req_ready), 32'b0100);
    chk("en_resume_rsp", 32'(rsp_valid), 0);
    nxt();
    req_valid = '0;
    repeat (4) nxt();

    // Reset mid-flight
    req_valid = 4'hF;
    #2;
    chk("mid_launch0", 32'(unit_launch), 1);
    nxt(); #2;
    chk("mid_launch1", 32'(unit_launch), 1);
    nxt();
    rst = 1'b1;
    #2;
    chk("mid_rst_ready", 32'(req_ready), 0);
    nxt();
    rst       = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("mid_rsp", 32'(rsp_valid), 0);
      chk("mid_busy", 32'(busy), 0);
      nxt();
    end
    #2;
    chk("mid_count", 32'(issue_count), 0);

    // Saturation: 10 transfers
    req_valid = 4'b0001;
    repeat (10) nxt();
    req_valid = '0;
    #2;
    chk("sat_main_count", 32'(issue_count), 10);
    chk("sat_count", 32'(s_issue_count), 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
